ai_i2s_tdm_clkgen: RTL and testbench

AI_I2S_TDM_CLKGEN -- requirements
Module: ai_i2s_tdm_clkgen

---
 rtl/ai_i2s_pkg.sv | 12 +
 rtl/ai_i2s_tdm_clkgen_if.sv | 34 +++
 rtl/ai_i2s_sck_div.sv | 34 +++
 rtl/ai_i2s_tdm_clkgen.sv | 97 +++++++++
 tb/tb_ai_i2s_tdm_clkgen.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ai_i2s_pkg.sv
// ai_i2s_pkg: shared mode/state enums, default sizes and the word-select rule for the I2S/LJ/TDM clock generator.
package ai_i2s_pkg;
  typedef enum logic [1:0] {MODE_I2S, MODE_LJ, MODE_TDM, MODE_RSVD} mode_e;
  typedef enum logic {ST_IDLE, ST_RUN} state_e;
  localparam int DEF_RATIO_WIDTH = 8;
  localparam int DEF_SLOT_W = 6;
  localparam int DEF_MAX_CH = 8;
  // I2S leads the slot boundary by one bit, so the last bit of a slot already shows the next slot's level.
  function automatic logic ws_level(mode_e m, logic slot0, logic slot1, logic bit0, logic msb);
    return m == MODE_I2S ? slot1 ^ bit0 : m == MODE_LJ ? slot0 : m == MODE_TDM && slot0 && msb;
  endfunction
endpackage

// File: rtl/ai_i2s_tdm_clkgen_if.sv
// ai_i2s_tdm_clkgen_if: configuration inputs and serial-clock/frame outputs of the clock generator.
interface ai_i2s_tdm_clkgen_if
  import ai_i2s_pkg::*;
#(
  parameter int RATIO_WIDTH = DEF_RATIO_WIDTH,
  parameter int SLOT_W = DEF_SLOT_W,
  parameter int MAX_CH = DEF_MAX_CH
);
  localparam int CH_W = $clog2(MAX_CH);
  logic enable;
  logic master_mode;
  logic [1:0] mode;
  logic [RATIO_WIDTH-1:0] ratio;
  logic [SLOT_W-1:0] slot_bits;
  logic [CH_W:0] num_ch;
  logic i2s_sck;
  logic i2s_ws;
  logic sck_oe;
  logic ws_oe;
  logic bit_strobe;
  logic sample_strobe;
  logic frame_start;
  logic [CH_W-1:0] slot_idx;
  logic [SLOT_W-1:0] bit_idx;
  logic cfg_err;
  modport master (
    output enable, master_mode, mode, ratio, slot_bits, num_ch,
    input i2s_sck, i2s_ws, sck_oe, ws_oe, bit_strobe, sample_strobe, frame_start, slot_idx, bit_idx, cfg_err
  );
  modport slave (
    input enable, master_mode, mode, ratio, slot_bits, num_ch,
    output i2s_sck, i2s_ws, sck_oe, ws_oe, bit_strobe, sample_strobe, frame_start, slot_idx, bit_idx, cfg_err
  );
endinterface

// File: rtl/ai_i2s_sck_div.sv
// ai_i2s_sck_div: SCK divider; edge pulses are issued the cycle before sck changes so callers can register them alongside it.
module ai_i2s_sck_div #(
  parameter int RATIO_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [RATIO_WIDTH-1:0] ratio,
  output logic                   sck,
  output logic                   rise_pulse,
  output logic                   fall_pulse
);
  logic [RATIO_WIDTH:0] r_cnt;
  logic [RATIO_WIDTH:0] w_cnt_inc;
  logic                 r_sck;
  logic                 w_tick;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_tick = en && w_cnt_inc == {1'b0, ratio} + 1'b1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else if (!en) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : w_cnt_inc;
      r_sck <= r_sck ^ w_tick;
    end
  end
  assign sck = r_sck;
  assign rise_pulse = w_tick & ~r_sck;
  assign fall_pulse = w_tick & r_sck;
endmodule

// File: rtl/ai_i2s_tdm_clkgen.sv
// ai_i2s_tdm_clkgen: I2S/LJ/TDM master SCK/WS generator with slot/bit tracking and frame-boundary config shadowing.
module ai_i2s_tdm_clkgen
  import ai_i2s_pkg::*;
#(
  parameter int RATIO_WIDTH = DEF_RATIO_WIDTH,
  parameter int SLOT_W = DEF_SLOT_W,
  parameter int MAX_CH = DEF_MAX_CH
) (
  input logic clk,
  input logic rst,
  ai_i2s_tdm_clkgen_if.slave bus
);
  localparam int CH_W = $clog2(MAX_CH);
  localparam logic [CH_W:0] MAX_NCH = (CH_W+1)'(MAX_CH);
  state_e r_state, w_state_nxt;
  mode_e r_mode, w_mode_in;
  logic [RATIO_WIDTH-1:0] r_ratio;
  logic [SLOT_W-1:0] r_sbits, r_bit;
  logic [CH_W:0] r_nch, w_nch;
  logic [CH_W-1:0] r_slot;
  logic r_cfg_err, r_fs, r_bs, r_ss;
  logic w_run, w_on, w_start, w_load, w_bad, w_wrap;
  logic w_sck, w_rise, w_fall, w_last_bit, w_last_slot, w_ws;
  assign w_mode_in = mode_e'(bus.mode);
  assign w_run = bus.enable & bus.master_mode & ~r_cfg_err;
  assign w_on = w_run & (r_state == ST_RUN);
  assign w_start = w_run & (r_state == ST_IDLE);
  assign w_bad = w_mode_in == MODE_RSVD || bus.slot_bits < SLOT_W'(2) ||
                 (w_mode_in == MODE_TDM && (bus.num_ch < (CH_W+1)'(2) || bus.num_ch > MAX_NCH));
  assign w_nch = r_mode == MODE_TDM ? r_nch : (CH_W+1)'(2);
  assign w_last_bit = r_bit == '0;
  assign w_last_slot = {1'b0, r_slot} == w_nch - 1'b1;
  assign w_wrap = w_fall & w_last_bit & w_last_slot;
  // Config is only sampled at run start and at the frame wrap, so mid-frame edits wait for the next frame.
  assign w_load = w_start | w_wrap;
  ai_i2s_sck_div #(.RATIO_WIDTH(RATIO_WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .en        (w_on),
    .ratio     (r_ratio),
    .sck       (w_sck),
    .rise_pulse(w_rise),
    .fall_pulse(w_fall)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = ST_IDLE;
    if (w_run) w_state_nxt = (r_state == ST_RUN || !w_bad) ? ST_RUN : ST_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg_err <= 1'b0;
      r_mode <= MODE_I2S;
      r_ratio <= '0;
      r_sbits <= '0;
      r_nch <= '0;
      r_slot <= '0;
      r_bit <= '0;
      r_fs <= 1'b0;
      r_bs <= 1'b0;
      r_ss <= 1'b0;
    end else begin
      r_cfg_err <= bus.enable & (r_cfg_err | (w_load & w_bad));
      r_fs <= w_load;
      r_bs <= w_fall;
      r_ss <= w_rise;
      if (w_load) begin
        r_mode <= w_mode_in;
        r_ratio <= bus.ratio;
        r_sbits <= bus.slot_bits;
        r_nch <= bus.num_ch;
        r_slot <= '0;
        r_bit <= bus.slot_bits - 1'b1;
      end else if (!w_on) begin
        r_slot <= '0;
        r_bit <= '0;
      end else if (w_fall) begin
        r_slot <= w_last_bit ? r_slot + 1'b1 : r_slot;
        r_bit <= w_last_bit ? r_sbits - 1'b1 : r_bit - 1'b1;
      end
    end
  end
  assign w_ws = ws_level(r_mode, r_slot == '0, r_slot == CH_W'(1), w_last_bit, r_bit == r_sbits - 1'b1);
  assign bus.sck_oe = w_run & ~rst;
  assign bus.ws_oe = w_run & ~rst;
  assign bus.i2s_sck = w_on & w_sck;
  assign bus.i2s_ws = w_on & w_ws;
  assign bus.bit_strobe = w_on & r_bs;
  assign bus.sample_strobe = w_on & r_ss;
  assign bus.frame_start = w_on & r_fs;
  assign bus.slot_idx = w_on ? r_slot : '0;
  assign bus.bit_idx = w_on ? r_bit : '0;
  assign bus.cfg_err = r_cfg_err;
endmodule

// File: tb/tb_ai_i2s_tdm_clkgen.sv
// tb_ai_i2s_tdm_clkgen: checks the clock generator cycle by cycle against an arithmetic frame/bit timing model.
module tb_ai_i2s_tdm_clkgen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  ai_i2s_tdm_clkgen_if bus();
  ai_i2s_tdm_clkgen dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic sck_oe, ws_oe, sck, ws, bs, ss, fs;
    logic [2:0] slot;
    logic [5:0] bidx;
  } obs_t;
  obs_t obs;
  assign obs = {bus.sck_oe, bus.ws_oe, bus.i2s_sck, bus.i2s_ws, bus.bit_strobe, bus.sample_strobe,
                bus.frame_start, bus.slot_idx, bus.bit_idx};
  // t counts clk cycles from the first cycle of a frame; each bit lasts one SCK period, low half first.
  function automatic obs_t model(int md, int ratio, int sb, int nch, int t, bit fresh);
    obs_t e;
    int half, p, bits, k, k1, ph, ne;
    ne = (md == 2) ? nch : 2;
    half = ratio + 1;
    p = 2 * half;
    bits = ne * sb;
    k = (t / p) % bits;
    k1 = (k + 1) % bits;
    ph = t % p;
    e.sck_oe = 1'b1;
    e.ws_oe = 1'b1;
    e.sck = ph >= half;
    e.ss = ph == half;
    e.bs = ph == 0 && !(fresh && t == 0);
    e.fs = t % (p * bits) == 0;
    e.slot = 3'(k / sb);
    e.bidx = 6'(sb - 1 - k % sb);
    e.ws = md == 0 ? (k1 / sb) == 1 : md == 1 ? (k / sb) == 0 : k == 0;
    return e;
  endfunction
  task automatic set_cfg(input int md, input int ratio, input int sb, input int nch);
    bus.mode = 2'(md);
    bus.ratio = 8'(ratio);
    bus.slot_bits = 6'(sb);
    bus.num_ch = 4'(nch);
  endtask
  task automatic start_run(input int md, input int ratio, input int sb, input int nch);
    set_cfg(md, ratio, sb, nch);
    bus.master_mode = 1'b1;
    bus.enable = 1'b1;
  endtask
  task automatic check_run(input string name, input int md, input int ratio, input int sb, input int nch,
                           input int t0, input int n, input bit fresh);
    obs_t e, got_b, exp_b;
    int bad_t;
    bad_t = -1;
    got_b = '0;
    exp_b = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = model(md, ratio, sb, nch, t0 + i, fresh);
      if (obs !== e && bad_t < 0) begin
        bad_t = t0 + i;
        got_b = obs;
        exp_b = e;
      end
    end
    checks++;
    if (bad_t >= 0) begin
      errors++;
      $display("FAIL %s: first diverging cycle t=%0d observed {oe,oe,sck,ws,bs,ss,fs,slot,bit}=%h required %h",
               name, bad_t, got_b, exp_b);
    end
  endtask
  task automatic stop_run(input string name);
    bus.enable = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL %s: outputs one cycle after run fell observed=%h required 0", name, obs);
    end
    @(negedge clk);
  endtask
  task automatic test_reset();
    start_run(1, 2, 5, 2);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== '0 || bus.cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: observed=%h cfg_err=%b required 0/0", obs, bus.cfg_err);
    end
    rst = 1'b0;
    check_run("reset_release_lj", 1, 2, 5, 2, 0, 130, 1'b1);
    stop_run("reset_release_stop");
  endtask
  task automatic test_i2s();
    start_run(0, 1, 16, 2);
    check_run("i2s_r1_s16", 0, 1, 16, 2, 0, 270, 1'b1);
    stop_run("i2s_stop");
  endtask
  task automatic test_lj();
    start_run(1, 0, 24, 2);
    check_run("lj_r0_s24", 1, 0, 24, 2, 0, 200, 1'b1);
    stop_run("lj_stop");
  endtask
  task automatic test_tdm();
    obs_t e;
    int nbs, nws, bad_t;
    nbs = 0;
    nws = 0;
    bad_t = -1;
    start_run(2, 0, 32, 8);
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      e = model(2, 0, 32, 8, t, 1'b1);
      if (obs !== e && bad_t < 0) bad_t = t;
      if (t >= 1 && t <= 512) nbs += int'(bus.bit_strobe);
      if (t < 512) nws += int'(bus.i2s_ws);
    end
    checks++;
    if (bad_t >= 0) begin
      errors++;
      $display("FAIL tdm8_s32: first diverging cycle t=%0d", bad_t);
    end
    checks++;
    if (nbs != 256) begin
      errors++;
      $display("FAIL tdm8_bit_strobes: observed %0d per frame required 256", nbs);
    end
    checks++;
    if (nws != 2) begin
      errors++;
      $display("FAIL tdm8_ws_width: ws high %0d clk per frame required 2", nws);
    end
    stop_run("tdm_stop");
  endtask
  task automatic test_midframe_change();
    start_run(2, 0, 4, 8);
    check_run("tdm8_head", 2, 0, 4, 8, 0, 20, 1'b1);
    bus.num_ch = 4'd4;
    check_run("tdm8_tail", 2, 0, 4, 8, 20, 44, 1'b0);
    check_run("tdm4_next", 2, 0, 4, 4, 0, 80, 1'b0);
    stop_run("midframe_stop");
  endtask
  task automatic test_cfg_err(input string name, input int md, input int sb, input int nch);
    int bad;
    bad = 0;
    set_cfg(md, 0, sb, nch);
    bus.master_mode = 1'b1;
    bus.enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.cfg_err !== 1'b1 || obs !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_latched: %0d of 12 cycles wrong, last obs=%h cfg_err=%b required 0/1", name, bad, obs, bus.cfg_err);
    end
    bus.enable = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_clear: cfg_err=%b after enable low required 0", name, bus.cfg_err);
    end
  endtask
  task automatic test_slave_mode();
    int bad;
    bad = 0;
    set_cfg(1, 0, 4, 2);
    bus.master_mode = 1'b0;
    bus.enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (obs !== '0 || bus.cfg_err !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL slave_quiet: %0d cycles active, last obs=%h required 0", bad, obs);
    end
    bus.master_mode = 1'b1;
    check_run("slave_to_master", 1, 0, 4, 2, 0, 40, 1'b1);
    stop_run("slave_stop");
  endtask
  task automatic test_reset_midrun();
    start_run(0, 1, 16, 2);
    check_run("pre_reset", 0, 1, 16, 2, 0, 50, 1'b1);
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== '0 || bus.cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: observed=%h cfg_err=%b required 0/0", obs, bus.cfg_err);
    end
    @(negedge clk);
    rst = 1'b0;
    check_run("post_reset", 0, 1, 16, 2, 0, 140, 1'b1);
    stop_run("drop_enable");
    start_run(0, 1, 16, 2);
    check_run("reenable", 0, 1, 16, 2, 0, 10, 1'b1);
    stop_run("reenable_stop");
  endtask
  task automatic test_ratio_max();
    start_run(0, 255, 2, 2);
    check_run("ratio_allones", 0, 255, 2, 2, 0, 1100, 1'b1);
    stop_run("ratio_stop");
  endtask
  task automatic test_random();
    int md, ratio, sb, nch, ne;
    for (int i = 0; i < 8; i++) begin
      md = int'($urandom_range(0, 2));
      ratio = int'($urandom_range(0, 3));
      sb = int'($urandom_range(2, 8));
      nch = int'($urandom_range(2, 8));
      ne = (md == 2) ? nch : 2;
      start_run(md, ratio, sb, nch);
      check_run($sformatf("rand%0d_m%0d_r%0d_s%0d_n%0d", i, md, ratio, sb, nch), md, ratio, sb, nch, 0,
                2 * ne * sb * 2 * (ratio + 1) + 3, 1'b1);
      stop_run("rand_stop");
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end
  endtask
  initial begin
    bus.enable = 1'b0;
    bus.master_mode = 1'b1;
    set_cfg(0, 0, 16, 2);
    @(negedge clk);
    test_reset();
    test_i2s();
    test_lj();
    test_tdm();
    test_midframe_change();
    test_cfg_err("mode3", 3, 16, 2);
    test_cfg_err("slot_bits1", 0, 1, 2);
    test_cfg_err("tdm_nch9", 2, 8, 9);
    test_slave_mode();
    test_reset_midrun();
    test_ratio_max();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
